// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and width helper for the TDC block family.
// Holds the accumulator FSM state type and the Hamming-weight width function
// used by the TDC top, the pop-count and the burst accumulator.
package tdc_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} tdc_accum_state_t;
   function automatic int hw_width(input int n);
      return $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/tdc_minmax_sum.sv
// tdc_minmax_sum: per-sample sum/min/max/range-error datapath for one burst.
// Ports:
//   clk_capture, rst    capture clock, synchronous active-high reset
//   clr                 zero the running accumulators (burst start)
//   en                  this cycle's sample is part of the burst
//   first               this is the first sample of the burst (loads min/max)
//   sample              Hamming weight sample
//   sum_nxt, min_nxt,   running values including this cycle's sample; the
//   max_nxt, err_nxt    owner captures them on the last sample edge
module tdc_minmax_sum import tdc_pkg::*; #(
   parameter int N = 64,
   parameter int LOG2_SAMPLES = 4,
   localparam int HW_W = hw_width(N),
   localparam int SUM_W = HW_W + LOG2_SAMPLES
) (
   input  logic             clk_capture,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             first,
   input  logic [HW_W-1:0]  sample,
   output logic [SUM_W-1:0] sum_nxt,
   output logic [HW_W-1:0]  min_nxt,
   output logic [HW_W-1:0]  max_nxt,
   output logic             err_nxt
);
   logic [SUM_W-1:0] sum;
   logic [HW_W-1:0] mn, mx;
   logic err;
   // sample only reaches the outputs through en-gated selects, so an
   // undriven hw_in outside the sampling window cannot leak into results
   always_comb begin
      sum_nxt = en ? sum + SUM_W'(sample) : sum;
      min_nxt = (en && (first || sample < mn)) ? sample : mn;
      max_nxt = (en && (first || sample > mx)) ? sample : mx;
      err_nxt = err || (en && sample > HW_W'(N));
   end
   always_ff @(posedge clk_capture) begin
      if (rst || clr) {sum, mn, mx, err} <= '0;
      else {sum, mn, mx, err} <= {sum_nxt, min_nxt, max_nxt, err_nxt};
   end
endmodule

// File: rtl/tdc_hw_accum.sv
// tdc_hw_accum: runs one TDC measurement burst and returns sum/mean/min/max/err.
// Ports:
//   clk_capture, rst    capture clock, synchronous active-high reset
//   start               burst request, honoured only while idle
//   hw_in               Hamming weight from the TDC top level
//   tdc_en              registered enable to the TDC
//   busy                settling or accumulating
//   res_valid/res_ready result handshake
//   res_sum, res_mean,  registered burst results, held until the next burst
//   res_min, res_max,   completes
//   res_err
module tdc_hw_accum import tdc_pkg::*; #(
   parameter int N = 64,
   parameter int LOG2_SAMPLES = 4,
   parameter int SETTLE_CYCLES = 3,
   localparam int HW_W = hw_width(N),
   localparam int SUM_W = HW_W + LOG2_SAMPLES
) (
   input  logic             clk_capture,
   input  logic             rst,
   input  logic             start,
   input  logic [HW_W-1:0]  hw_in,
   output logic             tdc_en,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SUM_W-1:0] res_sum,
   output logic [HW_W-1:0]  res_mean,
   output logic [HW_W-1:0]  res_min,
   output logic [HW_W-1:0]  res_max,
   output logic             res_err
);
   localparam int CNT_W = LOG2_SAMPLES + 1;
   localparam int SET_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'((1 << LOG2_SAMPLES) - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
   tdc_accum_state_t state;
   logic [CNT_W-1:0] samp_cnt;
   logic [SET_W-1:0] set_cnt;
   logic clr, en, first, last;
   logic [SUM_W-1:0] sum_nxt;
   logic [HW_W-1:0] min_nxt, max_nxt;
   logic err_nxt;
   assign busy = state == SETTLE || state == ACCUM;
   assign clr = state == IDLE && start;
   assign en = state == ACCUM;
   assign first = samp_cnt == '0;
   assign last = samp_cnt == SAMP_LAST;
   tdc_minmax_sum #(.N(N), .LOG2_SAMPLES(LOG2_SAMPLES)) u_dp (
      .clk_capture(clk_capture),
      .rst(rst),
      .clr(clr),
      .en(en),
      .first(first),
      .sample(hw_in),
      .sum_nxt(sum_nxt),
      .min_nxt(min_nxt),
      .max_nxt(max_nxt),
      .err_nxt(err_nxt)
   );
   // results are captured from the datapath's next values on the last sample
   // edge, so they are valid in the same cycle res_valid rises and survive
   // the accumulator clear of the following burst
   always_ff @(posedge clk_capture) begin
      if (rst) begin
         state <= IDLE;
         tdc_en <= 1'b0;
         res_valid <= 1'b0;
         samp_cnt <= '0;
         set_cnt <= '0;
         {res_sum, res_mean, res_min, res_max, res_err} <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= SETTLE_CYCLES == 0 ? ACCUM : SETTLE;
               tdc_en <= 1'b1;
               samp_cnt <= '0;
               set_cnt <= '0;
            end
            SETTLE: begin
               set_cnt <= set_cnt + 1'b1;
               if (set_cnt == SET_LAST) state <= ACCUM;
            end
            ACCUM: begin
               samp_cnt <= samp_cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  tdc_en <= 1'b0;
                  res_valid <= 1'b1;
                  res_sum <= sum_nxt;
                  res_mean <= sum_nxt[SUM_W-1:LOG2_SAMPLES];
                  res_min <= min_nxt;
                  res_max <= max_nxt;
                  res_err <= err_nxt;
               end
            end
            DONE: if (res_ready) begin
               state <= IDLE;
               res_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tdc_hw_accum.sv
// tb_tdc_hw_accum: randomized self-checking bench for tdc_hw_accum.
module tb_tdc_hw_accum;
   localparam int N = 64;
   localparam int SC = 3;
   localparam int S = 16;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, start, res_ready;
   logic [6:0] hw_in;
   logic tdc_en, busy, res_valid, res_err;
   logic [10:0] res_sum;
   logic [6:0] res_mean, res_min, res_max;
   logic start0, ready0;
   logic [6:0] hw0;
   logic en0, busy0, valid0, err0;
   logic [6:0] sum0, mean0, min0, max0;
   logic [35:0] got;
   logic [31:0] got0;
   int vectors = 0;
   int miscompares = 0;
   logic [6:0] smp [S];
   assign got = {res_valid, tdc_en, busy, res_sum, res_mean, res_min, res_max, res_err};
   assign got0 = {valid0, en0, busy0, sum0, mean0, min0, max0, err0};

   tdc_hw_accum #(.N(N), .LOG2_SAMPLES(4), .SETTLE_CYCLES(SC)) dut (
      .clk_capture(clk), .rst(rst), .start(start), .hw_in(hw_in),
      .tdc_en(tdc_en), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_mean(res_mean), .res_min(res_min), .res_max(res_max),
      .res_err(res_err)
   );

   tdc_hw_accum #(.N(N), .LOG2_SAMPLES(0), .SETTLE_CYCLES(0)) dut0 (
      .clk_capture(clk), .rst(rst), .start(start0), .hw_in(hw0),
      .tdc_en(en0), .busy(busy0), .res_valid(valid0), .res_ready(ready0),
      .res_sum(sum0), .res_mean(mean0), .res_min(min0), .res_max(max0),
      .res_err(err0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected DONE-state output vector for the samples in smp
   function automatic logic [35:0] model();
      int sum = 0;
      int mn = 1000;
      int mx = -1;
      bit err = 1'b0;
      for (int i = 0; i < S; i++) begin
         sum += int'(smp[i]);
         if (int'(smp[i]) < mn) mn = int'(smp[i]);
         if (int'(smp[i]) > mx) mx = int'(smp[i]);
         if (int'(smp[i]) > N) err = 1'b1;
      end
      return {3'b100, 11'(sum), 7'(sum / S), 7'(mn), 7'(mx), err};
   endfunction

   // issue start from IDLE, feed smp on the sampling edges, stop at res_valid
   task automatic burst(input bit poke, output int lat, output int en_cnt);
      lat = -1;
      en_cnt = 0;
      start = 1'b1;
      hw_in = 7'd30;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         en_cnt += int'(tdc_en);
         hw_in = 7'd30;
         if (c > SC && c <= SC + S) hw_in = smp[c-SC-1];
         start = poke ? 1'($urandom) : 1'b0;
         tick();
         if (res_valid) begin
            lat = c;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++;
         if (got !== 36'b0 || got0 !== 32'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got %h/%h required 0/0", got, got0);
         end
      end
   endtask

   task automatic test_nominal();
      int lat, en;
      logic [35:0] exp;
      for (int i = 0; i < S; i++) smp[i] = 7'(10 + i);
      burst(1'b0, lat, en);
      exp = {3'b100, 11'd280, 7'd17, 7'd10, 7'd25, 1'b0};
      vectors++;
      if (lat != SC + S || en != SC + S) begin
         miscompares++;
         $display("FAIL nominal_latency: got lat=%0d en=%0d required %0d", lat, en, SC + S);
      end
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL nominal_result: got %h required %h", got, exp);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      vectors++;
      if (got !== {3'b000, exp[32:0]}) begin
         miscompares++;
         $display("FAIL nominal_accept: got %h required %h", got, {3'b000, exp[32:0]});
      end
   endtask

   task automatic test_backpressure();
      int lat, en;
      logic [35:0] exp;
      for (int i = 0; i < S; i++) smp[i] = 7'($urandom_range(64));
      burst(1'b0, lat, en);
      exp = model();
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got %h required %h", i, got, exp);
         end
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      tick();
      vectors++;
      if (got !== {3'b000, exp[32:0]}) begin
         miscompares++;
         $display("FAIL bp_accept: got %h required %h", got, {3'b000, exp[32:0]});
      end
   endtask

   task automatic test_error();
      int lat, en;
      logic [35:0] exp;
      for (int i = 0; i < S; i++) smp[i] = 7'd64;
      smp[$urandom_range(S - 1)] = 7'd65;
      burst(1'b0, lat, en);
      exp = {3'b100, 11'd1025, 7'd64, 7'd64, 7'd65, 1'b1};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL error_result: got %h required %h", got, exp);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat, en;
      logic [35:0] exp;
      start = 1'b1;
      hw_in = 7'd30;
      tick();
      start = 1'b0;
      for (int c = 1; c <= SC + 6; c++) begin
         hw_in = c > SC ? 7'd99 : 7'd30;
         tick();
      end
      rst = 1'b1;
      hw_in = 7'd99;
      tick();
      rst = 1'b0;
      vectors++;
      if (got !== 36'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got %h required 0", got);
      end
      tick();
      vectors++;
      if (got !== 36'b0) begin
         miscompares++;
         $display("FAIL reset_mid_idle: got %h required 0", got);
      end
      for (int i = 0; i < S; i++) smp[i] = 7'd32;
      burst(1'b0, lat, en);
      exp = {3'b100, 11'd512, 7'd32, 7'd32, 7'd32, 1'b0};
      vectors++;
      if (got !== exp || lat != SC + S) begin
         miscompares++;
         $display("FAIL reset_mid_next: got %h lat=%0d required %h lat=%0d", got, lat, exp, SC + S);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_ignore_start();
      int lat, en;
      logic [35:0] exp;
      for (int i = 0; i < S; i++) smp[i] = 7'($urandom_range(127));
      burst(1'b1, lat, en);
      exp = model();
      vectors++;
      if (got !== exp || lat != SC + S) begin
         miscompares++;
         $display("FAIL ignore_busy: got %h lat=%0d required %h lat=%0d", got, lat, exp, SC + S);
      end
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         tick();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL ignore_done%0d: got %h required %h", i, got, exp);
         end
      end
      start = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         vectors++;
         if (got[35:33] !== 3'b000) begin
            miscompares++;
            $display("FAIL ignore_no_queue%0d: got flags %b required 000", i, got[35:33]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int seen [$];
      start = 1'b1;
      res_ready = 1'b1;
      hw_in = 7'd20;
      for (int c = 0; c <= 62; c++) begin
         tick();
         if (res_valid) begin
            seen.push_back(c);
            vectors++;
            if (res_sum !== 11'd320) begin
               miscompares++;
               $display("FAIL b2b_sum: got %0d required 320", res_sum);
            end
         end
      end
      start = 1'b0;
      res_ready = 1'b0;
      tick();
      vectors++;
      if (seen.size() != 3 || seen[0] != 19 || seen[1] != 40 || seen[2] != 61) begin
         miscompares++;
         $display("FAIL b2b_edges: got %p required '{19, 40, 61}", seen);
      end
      vectors++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle: got busy=%b valid=%b required 0 0", busy, res_valid);
      end
   endtask

   task automatic test_random();
      int lat, en, w;
      logic [35:0] exp;
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < S; i++)
            smp[i] = 7'($urandom_range($urandom_range(3) == 0 ? 127 : 64));
         burst(1'($urandom), lat, en);
         exp = model();
         vectors++;
         if (got !== exp || lat != SC + S || en != SC + S) begin
            miscompares++;
            $display("FAIL random%0d: got %h lat=%0d en=%0d required %h lat=%0d", b, got, lat, en, exp, SC + S);
         end
         w = $urandom_range(3);
         for (int i = 0; i < w; i++) tick();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL random_hold%0d: got %h required %h", b, got, exp);
         end
         res_ready = 1'b1;
         tick();
         res_ready = 1'b0;
      end
   endtask

   task automatic test_corner();
      logic [6:0] v;
      for (int b = 0; b < 5; b++) begin
         v = b == 0 ? 7'd64 : 7'($urandom_range(127));
         start0 = 1'b1;
         hw0 = 7'd5;
         tick();
         start0 = 1'b0;
         hw0 = v;
         vectors++;
         if (got0[31:29] !== 3'b011) begin
            miscompares++;
            $display("FAIL corner_start%0d: got flags %b required 011", b, got0[31:29]);
         end
         tick();
         vectors++;
         if (got0 !== {3'b100, v, v, v, v, v > 7'd64}) begin
            miscompares++;
            $display("FAIL corner_result%0d: got %h required %h", b, got0, {3'b100, v, v, v, v, v > 7'd64});
         end
         ready0 = 1'b1;
         tick();
         ready0 = 1'b0;
         vectors++;
         if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL corner_accept%0d: got valid=%b busy=%b required 0 0", b, valid0, busy0);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      res_ready = 1'b0;
      hw_in = 7'd0;
      start0 = 1'b0;
      ready0 = 1'b0;
      hw0 = 7'd0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_error();
      test_reset_mid();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_corner();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tdc_hw_accum.md
Name: tdc_hw_accum

Overview:
- Sits directly downstream of the TDC top level and consumes its Hamming-weight output `hw`.
- Runs one measurement burst on request:
  - drives the TDC enable;
  - discards the TDC pipeline fill;
  - accumulates 2^LOG2_SAMPLES consecutive `hw` samples;
  - returns sum, truncated mean, min, max and a range-error flag over a valid/ready handshake.
- Lets software or the scan interface read a stable, averaged delay code instead of a per-cycle value.

Parameters:
- N, 64: TDC delay-line length. HW_W = $clog2(N)+1 is the `hw` width.
- LOG2_SAMPLES, 4: samples per burst S = 2^LOG2_SAMPLES. Legal range 0..8.
- SETTLE_CYCLES, 3: cycles of `hw` discarded after `tdc_en` rises. Covers capture reg + sync stages + pop-count register. 0 is legal.

Ports:
- clk_capture  in  1  capture clock, same clock as the TDC capture/pop-count domain
- rst  in  1  synchronous, active-high reset
- start  in  1  request a burst; sampled only in IDLE
- hw_in  in  HW_W  Hamming weight from the TDC top level
- tdc_en  out  1  enable to the TDC top level; registered
- busy  out  1  high in SETTLE or ACCUM
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_sum  out  HW_W+LOG2_SAMPLES  sum of S samples
- res_mean  out  HW_W  res_sum >> LOG2_SAMPLES, truncated
- res_min  out  HW_W  minimum sample
- res_max  out  HW_W  maximum sample
- res_err  out  1  at least one sample had hw_in > N

Behaviour:
- Reset (rst=1 at a clk_capture edge):
  - state goes to IDLE from any state, including mid-burst; the burst is abandoned and no result is produced.
  - tdc_en, busy, res_valid, res_sum, res_mean, res_min, res_max, res_err all go to 0.
- States: IDLE, SETTLE, ACCUM, DONE.
- IDLE:
  - tdc_en=0, busy=0, res_valid=0.
  - start=1 at edge k: clear accumulators; go to SETTLE, or to ACCUM if SETTLE_CYCLES=0; tdc_en=1 from edge k.
- SETTLE:
  - Counts SETTLE_CYCLES cycles; hw_in is ignored.
  - At edge k+SETTLE_CYCLES, goes to ACCUM.
- ACCUM:
  - Samples hw_in on S consecutive edges, k+SETTLE_CYCLES+1 through k+SETTLE_CYCLES+S.
  - Each sample: sum += hw_in; min/max updated. The first sample loads both min and max directly.
  - Any hw_in > N sets the sticky err bit.
  - On the S-th sample edge: state goes to DONE, tdc_en goes to 0, busy goes to 0, res_valid goes to 1.
  - All result outputs are registered and valid in the same cycle res_valid rises.
  - Latency: res_valid rises SETTLE_CYCLES+S edges after the edge that accepted start.
- DONE:
  - res_valid=1; all res_* held stable until accepted.
  - res_valid & res_ready at an edge: go to IDLE, res_valid goes to 0, res_* hold their last values.
  - res_ready may be high before res_valid. In that case the transfer completes on the first DONE edge.
- start is ignored in SETTLE, ACCUM and DONE; it is not queued.
- start held high continuously: a new burst begins on the edge after acceptance (first IDLE edge). Back-to-back cost is one IDLE cycle.
- Widths:
  - Sum accumulator is HW_W+LOG2_SAMPLES bits and cannot overflow, even with err samples (max 2^HW_W-1 per sample).
  - Sample counter is LOG2_SAMPLES+1 bits and wraps only via clear on start.
- LOG2_SAMPLES=0: single sample; res_sum = res_mean = res_min = res_max = that sample.
- hw_in is only used in ACCUM; X on hw_in outside ACCUM must not propagate.

Decomposition:
- Package tdc_pkg:
  - state enum tdc_accum_state_t {IDLE, SETTLE, ACCUM, DONE}, 2-bit encoding;
  - function hw_width(N) returning $clog2(N)+1, shared with the TDC top and pop-count.
- One sub-module, tdc_minmax_sum: per-sample sum/min/max/err datapath with clear and load-first control.
- The FSM and counters stay in tdc_hw_accum.

Test Plan:
- Reset/idle: rst for 2 cycles, then idle 10 cycles -> all outputs 0, tdc_en never rises.
- Nominal, defaults (N=64, S=16, SETTLE=3): start pulse at edge 0; hw_in = 30 during SETTLE, ramp 10..25 during ACCUM -> tdc_en high edges 0..18, res_valid at edge 19, sum=280, mean=17, min=10, max=25, err=0.
- Backpressure and error:
  - res_ready low for 5 cycles after res_valid -> results held stable; accepted on first ready edge; returns to IDLE.
  - Separate burst with one sample hw_in=65 and rest 64 -> err=1, max=65, sum=1025, mean=64.
- Reset mid-burst: rst at ACCUM sample 7 -> IDLE next edge, all outputs 0. Following burst of constant 32 -> sum=512, min=max=mean=32, err=0; no leftover accumulation.
- Start while busy plus continuous start: start pulses during SETTLE/ACCUM/DONE -> ignored, exactly one result. start held high -> new burst one edge after each acceptance.
- Corner params: LOG2_SAMPLES=0, SETTLE_CYCLES=0, hw_in=64 -> res_valid one edge after start; sum=mean=min=max=64.
